fpadd_arbiter: RTL
==================

// Module: fpadd_arbiter
// PURPOSE
// - Shares one serial-operand fpadder among NREQ requesters; round-robin arbitration.
// - Drives the adder's single operand port over two cycles, collects its sum and routes it back.
// - Sits between client blocks and the fpadder instance; the adder runs continuously.
// PARAMETERS
// - NREQ     4   number of requesters (2..8)
// - TIMEOUT  64  max cycles in WAIT_RDY with a job outstanding (FPADD_ARB_TIMEOUT_EN only)
// PORTS
// - clock     in   1        system clock; all logic on posedge
// - reset     in   1        synchronous, active-high reset
// - req       in   NREQ     per-requester request; held with operands until gnt
// - opa       in   NREQ*32  operand A, IEEE-754 single; requester i at [32*i+31:32*i]
// - opb       in   NREQ*32  operand B, same packing
// - gnt       out  NREQ     one-hot, 1-cycle pulse: operands captured
// - done      out  NREQ     one-hot, 1-cycle pulse: result valid for that requester
// - result    out  32       sum; valid when any done bit is set, else holds last value
// - err       out  1        with done: job timed out, result forced to 32'h7FC00000
// - busy      out  1        job issued to the adder, result not yet returned
// - add_a     out  32       to fpadder a
// - add_sum   in   32       from fpadder sum
// - add_ready in   1        from fpadder ready
// BEHAVIOUR
// - Reset values: state=WAIT_RDY, gnt=0, done=0, result=0, err=0, busy=0, add_a=0, rr_ptr=0,
//   job_v=0, owner=0. Reset mid-job drops the job silently: no done, no gnt.
// - Adder contract: the cycle after add_ready=1 the adder samples operand A, the next cycle
//   operand B; add_a is registered so it holds A and B exactly in those cycles.
// - FSM: WAIT_RDY -(add_ready)-> SEND_A -> SEND_B -> WAIT_RDY. Every ready edge leads to
//   SEND_A even with no request (dummy job, add_a=0 in both cycles, job_v=0).
// - On the add_ready cycle in WAIT_RDY, all of the following take effect at the same edge:
//   - If job_v: result<=add_sum, done<=onehot(owner), err<=0.
//   - Arbitrate: winner = first req[i]=1 searching from rr_ptr upward, modulo NREQ.
//     If a winner exists: latch opb, add_a<=opa[winner], gnt<=onehot(winner), owner<=winner,
//     rr_ptr<=winner+1 (wraps to 0), job_v<=1 (takes effect after the done decision above).
//     If none: add_a<=0, job_v<=0, rr_ptr unchanged.
// - SEND_A: add_a<=latched opb. SEND_B: add_a<=0, busy=job_v.
// - First add_ready after reset: job_v=0, so the sum is discarded.
// - Same requester may receive done (old job) and gnt (new job) in the same cycle.
// - Requester must drop req or change operands after gnt. req still high in the gnt cycle does
//   not re-grant, because the next arbitration point is at least 5 cycles later.
// - add_ready while in SEND_A/SEND_B is ignored (protocol violation).
// - Latency: gnt = ready+1 cycle; done = the cycle after the next ready (variable, at least 6).
// CONFIGURATION
// - FPADD_ARB_TIMEOUT_EN defined: 8-bit wdog counts WAIT_RDY cycles while job_v=1 and clears on
//   leaving WAIT_RDY. At wdog==TIMEOUT: done<=onehot(owner), err<=1, result<=32'h7FC00000,
//   job_v<=0. The next add_ready is then handled as a dummy result.
// - Not defined: no counter; err tied to 0; WAIT_RDY waits indefinitely.
// TESTING
// - Single requester 0: opa=3F800000, opb=40000000 -> gnt[0] one cycle after ready;
//   done[0] with result=40400000, err=0.
// - req=4'b1111, distinct operands -> grants in order 0,1,2,3,0; each done carries its own sum
//   (3FC00000+40200000 -> 40800000).
// - rr_ptr=3, req=4'b1001 -> grant 3, then 0 on the next ready.
// - Idle for 30 cycles after reset -> no gnt, no done, add_a=0, busy=0 throughout.
// - Assert reset during SEND_B -> no done afterwards; first post-reset ready result discarded.
// - FPADD_ARB_TIMEOUT_EN, TIMEOUT=8, add_ready forced low after grant -> done with err=1 and
//   result=7FC00000 exactly 8 cycles into WAIT_RDY.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one serial-operand fpadder among NREQ requesters.
// Optional job watchdog (adds parameter TIMEOUT): define FPADD_ARB_TIMEOUT_EN.
module fpadd_arbiter #(
  parameter int NREQ = 4
`ifdef FPADD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   opa,
  input  logic [NREQ*32-1:0]   opb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic [31:0]          add_a,
  input  logic [31:0]          add_sum,
  input  logic                 add_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_WAIT_RDY,
    ST_SEND_A,
    ST_SEND_B
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic              busy_q, busy_d;
  logic [31:0]       add_a_q, add_a_d;
  logic [31:0]       opb_lat_q, opb_lat_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              job_v_q, job_v_d;
  logic [IW-1:0]     owner_q, owner_d;
`ifdef FPADD_ARB_TIMEOUT_EN
  logic              err_q, err_d;
  logic [7:0]        wdog_q, wdog_d;
`endif

  // Arbitration: first requester at or above rr_ptr, wrapping modulo NREQ.
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [31:0]       win_opa, win_opb;
  logic [NREQ-1:0]   win_oh, owner_oh;
  logic [IW-1:0]     rr_next;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_opa   = '0;
    win_opb   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k >= NREQ) ? IW'(int'(rr_ptr_q) + k - NREQ)
                                          : IW'(int'(rr_ptr_q) + k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_opa = opa[32*i +: 32];
        win_opb = opb[32*i +: 32];
      end
    end
  end

  assign win_oh   = NREQ'(1) << win_idx;
  assign owner_oh = NREQ'(1) << owner_q;
  assign rr_next  = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_WAIT_RDY;
    else       state_q <= state_d;
  end

  // FSM next state: every ready edge starts a two-cycle operand transfer, job or not.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_RDY: if (add_ready) state_d = ST_SEND_A;
      ST_SEND_A:   state_d = ST_SEND_B;
      ST_SEND_B:   state_d = ST_WAIT_RDY;
      default:     state_d = ST_WAIT_RDY;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    gnt_d     = '0;
    done_d    = '0;
    result_d  = result_q;
    busy_d    = busy_q;
    add_a_d   = add_a_q;
    opb_lat_d = opb_lat_q;
    rr_ptr_d  = rr_ptr_q;
    job_v_d   = job_v_q;
    owner_d   = owner_q;
`ifdef FPADD_ARB_TIMEOUT_EN
    err_d     = 1'b0;
    wdog_d    = '0;
`endif
    unique case (state_q)
      ST_WAIT_RDY: begin
        if (add_ready) begin
          // Retire the outstanding job before the new grant overwrites owner/job_v.
          if (job_v_q) begin
            result_d = add_sum;
            done_d   = owner_oh;
            busy_d   = 1'b0;
          end
          if (win_found) begin
            add_a_d   = win_opa;
            opb_lat_d = win_opb;
            gnt_d     = win_oh;
            owner_d   = win_idx;
            rr_ptr_d  = rr_next;
            job_v_d   = 1'b1;
          end else begin
            add_a_d   = '0;
            opb_lat_d = '0;
            job_v_d   = 1'b0;
          end
        end
`ifdef FPADD_ARB_TIMEOUT_EN
        else if (job_v_q) begin
          wdog_d = wdog_q + 8'd1;
          if (wdog_d == 8'(TIMEOUT)) begin
            done_d   = owner_oh;
            err_d    = 1'b1;
            result_d = 32'h7FC0_0000;
            job_v_d  = 1'b0;
            busy_d   = 1'b0;
            wdog_d   = '0;
          end
        end
`endif
      end
      ST_SEND_A: add_a_d = opb_lat_q;
      ST_SEND_B: begin
        add_a_d = '0;
        busy_d  = job_v_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      add_a_q   <= '0;
      opb_lat_q <= '0;
      rr_ptr_q  <= '0;
      job_v_q   <= 1'b0;
      owner_q   <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      wdog_q    <= '0;
`endif
    end else begin
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      add_a_q   <= add_a_d;
      opb_lat_q <= opb_lat_d;
      rr_ptr_q  <= rr_ptr_d;
      job_v_q   <= job_v_d;
      owner_q   <= owner_d;
`ifdef FPADD_ARB_TIMEOUT_EN
      err_q     <= err_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign add_a  = add_a_q;
`ifdef FPADD_ARB_TIMEOUT_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule
